// File: rtl/minx_pkg.sv
// Shared definitions for the Minx system bus: bus command encodings,
// arbiter state encoding and the round-robin pointer advance helper.
package minx_pkg;

    localparam logic [1:0] BUS_COMMAND_IDLE      = 2'd0;
    localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'd1;
    localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'd2;
    localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'd3;

    typedef enum logic [1:0] {
        CPU_OWN,
        RELEASE_WAIT,
        GRANTED,
        HANDBACK
    } arb_state_t;

    // Pointer after a grant: one past the winner, wrapping from the last
    // requesting master back to master 1 (master 0 never arbitrates).
    function automatic logic [2:0] rr_next(input logic [2:0] winner, input int num_masters);
        if (int'(winner) >= num_masters - 1) return 3'd1;
        return winner + 3'd1;
    endfunction

endpackage

// File: rtl/minx_arb_pick.sv
// Combinational winner selection among masters 1..N-1.
// mode=0: lowest index wins. mode=1: search starts at ptr and wraps to 1.
// idx is the absolute master index (1..N-1); onehot is aligned with req.
module minx_arb_pick
    import minx_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-2:0] req,
    input  logic                   mode,
    input  logic [2:0]             ptr,
    output logic [NUM_MASTERS-2:0] onehot,
    output logic [2:0]             idx,
    output logic                   valid
);

    localparam int NR = NUM_MASTERS - 1;

    logic [3:0] start;
    logic [3:0] pos;

    // Walk the request vector once from the start slot, taking the first hit.
    always_comb begin
        start = (mode && ptr != 3'd0) ? ({1'b0, ptr} - 4'd1) : 4'd0;
        pos   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NR; k++) begin
            pos = start + 4'(k);
            if (pos >= 4'(NR)) pos = pos - 4'(NR);
            for (int j = 0; j < NR; j++) begin
                if (!valid && pos == 4'(j) && req[j]) begin
                    valid = 1'b1;
                    idx   = 3'(j + 1);
                end
            end
        end
        for (int j = 0; j < NR; j++) begin
            onehot[j] = valid && (idx == 3'(j + 1));
        end
    end

endmodule

// File: rtl/minx_bus_arbiter.sv
// N-master system bus arbiter. Master 0 (core) owns the bus by default and
// is asked to release it via cpu_bus_request/cpu_bus_ack; masters 1..N-1
// are granted by fixed priority or round-robin and handed over directly
// between each other without returning the bus to the core.
// Optional grant hold limit: define MINX_ARB_HOLD_TIMEOUT_EN.
module minx_bus_arbiter
    import minx_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 8,
    parameter int ARB_MODE    = 0,
    parameter int MAX_HOLD    = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MASTERS-2:0]      req,
    output logic [NUM_MASTERS-2:0]      gnt,
    output logic                        cpu_bus_request,
    input  logic                        cpu_bus_ack,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data,
    input  logic [NUM_MASTERS-1:0]      m_read,
    input  logic [NUM_MASTERS-1:0]      m_write,
    input  logic [NUM_MASTERS*2-1:0]    m_bus_status,
    output logic [ADDR_W-1:0]           address_out,
    output logic [DATA_W-1:0]           data_out,
    output logic                        read,
    output logic                        write,
    output logic [1:0]                  bus_status,
    output logic [2:0]                  owner,
    output logic                        hold_error
);

    localparam int NR = NUM_MASTERS - 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD < 2 || MAX_HOLD > 8192) begin : g_bad_param
        $error("minx_bus_arbiter: parameter out of range");
    end

    arb_state_t    state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [NR-1:0] gnt_q, gnt_d;
    logic          cpu_req_q, cpu_req_d;
    logic          grant_now;
    logic          own_req;
    logic          timeout;
    logic [NR-1:0] pick_req, pick_oh;
    logic [2:0]    pick_idx;
    logic          pick_valid;

    // Owner's req comes through its grant bit; the owner never competes
    // in its own re-arbitration (it has released or been revoked).
    assign own_req  = |(req & gnt_q);
    assign pick_req = req & ~gnt_q;

    minx_arb_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req    (pick_req),
        .mode   (ARB_MODE == 1),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

`ifdef MINX_ARB_HOLD_TIMEOUT_EN
    logic [12:0] hold_cnt_q, hold_cnt_d;
    logic        hold_err_q, hold_err_d;

    assign timeout = (state_q == GRANTED) && (hold_cnt_q == 13'(MAX_HOLD - 1));

    // Hold counter restarts on every grant and counts GRANTED cycles.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q | timeout;
        if (grant_now)                hold_cnt_d = '0;
        else if (state_q == GRANTED)  hold_cnt_d = hold_cnt_q + 13'd1;
    end

    // Hold counter and sticky revocation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

    assign hold_error = hold_err_q;
`else
    assign timeout    = 1'b0;
    assign hold_error = 1'b0;
`endif

    // Next-state logic for the ownership handshake and grant handover.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cpu_req_d = cpu_req_q;
        grant_now = 1'b0;
        case (state_q)
            CPU_OWN: begin
                if (|req) begin
                    cpu_req_d = 1'b1;
                    state_d   = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (!(|req)) begin
                    cpu_req_d = 1'b0;
                    state_d   = HANDBACK;
                end else if (cpu_bus_ack) begin
                    grant_now = 1'b1;
                end
            end
            GRANTED: begin
                if (!own_req || timeout) begin
                    if (pick_valid) begin
                        grant_now = 1'b1;
                    end else begin
                        gnt_d     = '0;
                        cpu_req_d = 1'b0;
                        state_d   = HANDBACK;
                    end
                end
            end
            HANDBACK: begin
                if (!cpu_bus_ack) begin
                    state_d = CPU_OWN;
                    owner_d = 3'd0;
                end
            end
            default: state_d = CPU_OWN;
        endcase
        if (grant_now) begin
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            ptr_d   = rr_next(pick_idx, NUM_MASTERS);
            state_d = GRANTED;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CPU_OWN;
            owner_q   <= 3'd0;
            ptr_q     <= 3'd1;
            gnt_q     <= '0;
            cpu_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cpu_req_q <= cpu_req_d;
        end
    end

    // Bus mux on the registered owner; strobes are quiet during handover.
    always_comb begin
        address_out = m_address[ADDR_W-1:0];
        data_out    = m_data[DATA_W-1:0];
        read        = m_read[0];
        write       = m_write[0];
        bus_status  = m_bus_status[1:0];
        for (int i = 1; i < NUM_MASTERS; i++) begin
            if (owner_q == 3'(i)) begin
                address_out = m_address[i*ADDR_W +: ADDR_W];
                data_out    = m_data[i*DATA_W +: DATA_W];
                read        = m_read[i];
                write       = m_write[i];
                bus_status  = m_bus_status[i*2 +: 2];
            end
        end
        if (state_q == RELEASE_WAIT || state_q == HANDBACK) begin
            read       = 1'b0;
            write      = 1'b0;
            bus_status = BUS_COMMAND_IDLE;
        end
    end

    assign gnt             = gnt_q;
    assign cpu_bus_request = cpu_req_q;
    assign owner           = owner_q;

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// Bench for minx_bus_arbiter: two instances (fixed priority and round-robin)
// share req and bus inputs; each has its own cpu_bus_ack. A phase-level
// reference model tracks both.
module tb_minx_bus_arbiter;

    localparam int NM   = 3;
    localparam int NR   = NM - 1;
    localparam int AW   = 24;
    localparam int DW   = 8;
    localparam int MAXH = 16;
`ifdef MINX_ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req;
    logic             ack [2];
    logic [NM*AW-1:0] m_address;
    logic [NM*DW-1:0] m_data;
    logic [NM-1:0]    m_read, m_write;
    logic [NM*2-1:0]  m_bus_status;

    logic [NR-1:0] gnt [2];
    logic          cpr [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] data [2];
    logic          rd [2];
    logic          wr [2];
    logic [1:0]    bs [2];
    logic [2:0]    own [2];
    logic          herr [2];

    int checks = 0;
    int failures = 0;

    // model: phase 0=core owns, 1=waiting for release, 2=granted, 3=handing back
    int ph [2];
    int mown [2];
    int mrr [2];
    int mheld [2];
    bit mherr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        minx_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW),
                           .ARB_MODE(g), .MAX_HOLD(MAXH)) u_dut (
            .clk(clk), .reset(reset), .req(req), .gnt(gnt[g]),
            .cpu_bus_request(cpr[g]), .cpu_bus_ack(ack[g]),
            .m_address(m_address), .m_data(m_data), .m_read(m_read),
            .m_write(m_write), .m_bus_status(m_bus_status),
            .address_out(addr[g]), .data_out(data[g]), .read(rd[g]),
            .write(wr[g]), .bus_status(bs[g]), .owner(own[g]),
            .hold_error(herr[g]));
    end

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return m_address[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return m_data[i*DW +: DW];
    endfunction

    function automatic logic [1:0] bs_of(input int i);
        return m_bus_status[i*2 +: 2];
    endfunction

    function automatic int pick(input int mode, input int rr, input logic [NR-1:0] r);
        if (mode == 0) begin
            for (int i = 1; i < NM; i++) if (r[i-1]) return i;
        end else begin
            for (int k = 0; k < NM - 1; k++) begin
                int i;
                i = 1 + ((rr - 1 + k) % (NM - 1));
                if (r[i-1]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; mown[d] = 0; mrr[d] = 1; mheld[d] = 0; mherr[d] = 1'b0;
        end
    endtask

    task automatic model_grant(input int d, input int w);
        mown[d]  = w;
        ph[d]    = 2;
        mheld[d] = 0;
        mrr[d]   = (w == NM - 1) ? 1 : w + 1;
    endtask

    task automatic model_step(input int d, input logic [NR-1:0] r, input logic a);
        bit expire;
        logic [NR-1:0] others;
        case (ph[d])
            0: if (r != 0) ph[d] = 1;
            1: begin
                if (r == 0) ph[d] = 3;
                else if (a) model_grant(d, pick(d, mrr[d], r));
            end
            2: begin
                expire = TO_EN && (mheld[d] == MAXH - 1);
                if (!r[mown[d]-1] || expire) begin
                    others = r;
                    others[mown[d]-1] = 1'b0;
                    if (expire) mherr[d] = 1'b1;
                    if (others != 0) model_grant(d, pick(d, mrr[d], others));
                    else ph[d] = 3;
                end else begin
                    mheld[d]++;
                end
            end
            default: if (!a) begin ph[d] = 0; mown[d] = 0; end
        endcase
    endtask

    function automatic logic [63:0] exp_obs(input int d);
        logic idle;
        logic [42:0] v;
        idle = (ph[d] == 1 || ph[d] == 3);
        v = {(ph[d] == 2) ? NR'(1 << (mown[d] - 1)) : NR'(0),
             (ph[d] == 1 || ph[d] == 2), 3'(mown[d]),
             addr_of(mown[d]), data_of(mown[d]),
             idle ? 1'b0 : m_read[mown[d]], idle ? 1'b0 : m_write[mown[d]],
             idle ? 2'b00 : bs_of(mown[d]), mherr[d]};
        return 64'(v);
    endfunction

    function automatic logic [63:0] act_obs(input int d);
        logic [42:0] v;
        v = {gnt[d], cpr[d], own[d], addr[d], data[d], rd[d], wr[d], bs[d], herr[d]};
        return 64'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d, req, ack[d]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        req = '0;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic          ack;
        logic [NR-1:0] gnt;
        logic          cpr;
        logic [2:0]    own;
        logic          idle;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int cnt, held, prev, cur, n;
        int got [4];
        logic [NR-1:0] r;

        tbl[0]  = '{2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{2'b10, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};
        tbl[2]  = '{2'b10, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};
        tbl[3]  = '{2'b10, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};
        tbl[4]  = '{2'b10, 1'b1, 2'b10, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{2'b10, 1'b1, 2'b10, 1'b1, 3'd2, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 2'b10, 1'b1, 3'd2, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 2'b10, 1'b1, 3'd2, 1'b0};
        tbl[8]  = '{2'b00, 1'b1, 2'b00, 1'b0, 3'd2, 1'b1};
        tbl[9]  = '{2'b00, 1'b1, 2'b00, 1'b0, 3'd2, 1'b1};
        tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
        tbl[11] = '{2'b01, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};
        tbl[12] = '{2'b11, 1'b1, 2'b01, 1'b1, 3'd1, 1'b0};
        tbl[13] = '{2'b10, 1'b1, 2'b10, 1'b1, 3'd2, 1'b0};
        tbl[14] = '{2'b01, 1'b1, 2'b01, 1'b1, 3'd1, 1'b0};
        tbl[15] = '{2'b00, 1'b0, 2'b00, 1'b0, 3'd1, 1'b1};
        tbl[16] = '{2'b01, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
        tbl[17] = '{2'b01, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1};
        tbl[18] = '{2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1};
        tbl[19] = '{2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};

        m_address    = {24'hC2C2C2, 24'hB1B1B1, 24'hA0A0A0};
        m_data       = {8'h22, 8'h11, 8'h00};
        m_read       = '1;
        m_write      = '0;
        m_bus_status = {2'd1, 2'd2, 2'd3};

        // reset state
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_gnt_m%0d", d), 64'(gnt[d]), 64'(0));
            check($sformatf("reset_cpr_m%0d", d), 64'(cpr[d]), 64'(0));
            check($sformatf("reset_owner_m%0d", d), 64'(own[d]), 64'(0));
            check($sformatf("reset_herr_m%0d", d), 64'(herr[d]), 64'(0));
            check($sformatf("reset_addr_m%0d", d), 64'(addr[d]), 64'(24'hA0A0A0));
        end

        // table-driven handshake sequences (identical in both modes)
        for (int i = 0; i < 20; i++) begin
            req    = tbl[i].req;
            ack[0] = tbl[i].ack;
            ack[1] = tbl[i].ack;
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("tbl%0d_gnt_m%0d", i, d), 64'(gnt[d]), 64'(tbl[i].gnt));
                check($sformatf("tbl%0d_cpr_m%0d", i, d), 64'(cpr[d]), 64'(tbl[i].cpr));
                check($sformatf("tbl%0d_owner_m%0d", i, d), 64'(own[d]), 64'(tbl[i].own));
                check($sformatf("tbl%0d_addr_m%0d", i, d), 64'(addr[d]), 64'(addr_of(int'(tbl[i].own))));
                check($sformatf("tbl%0d_read_m%0d", i, d), 64'(rd[d]), 64'(!tbl[i].idle));
                check($sformatf("tbl%0d_bs_m%0d", i, d), 64'(bs[d]),
                      64'(tbl[i].idle ? 2'b00 : bs_of(int'(tbl[i].own))));
            end
        end

        // asynchronous reset in the middle of a grant to master 2
        do_reset();
        req = 2'b10;
        tick();
        ack[0] = 1'b1;
        ack[1] = 1'b1;
        tick();
        tick();
        check("midreset_pre_owner", 64'(own[0]), 64'(2));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midreset_owner_m%0d", d), 64'(own[d]), 64'(0));
            check($sformatf("midreset_gnt_m%0d", d), 64'(gnt[d]), 64'(0));
            check($sformatf("midreset_cpr_m%0d", d), 64'(cpr[d]), 64'(0));
            check($sformatf("midreset_addr_m%0d", d), 64'(addr[d]), 64'(addr_of(0)));
            check($sformatf("midreset_read_m%0d", d), 64'(rd[d]), 64'(m_read[0]));
        end
        @(negedge clk);
        req = '0;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        reset = 1'b1;

        // round-robin: both masters keep requesting, each releases after 5 cycles
        do_reset();
        held = 0; prev = 0; n = 0;
        for (int i = 0; i < 4; i++) got[i] = 0;
        for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
            ack[0] = cpr[0];
            ack[1] = cpr[1];
            r = 2'b11;
            if (gnt[1] != 0) begin
                cur = int'(own[1]);
                if (cur != prev) begin
                    got[n] = cur;
                    n++;
                    prev = cur;
                    held = 0;
                end
                held++;
                if (held == 5) r[cur-1] = 1'b0;
            end
            req = r;
            tick();
        end
        check("rr_grant0", 64'(got[0]), 64'(1));
        check("rr_grant1", 64'(got[1]), 64'(2));
        check("rr_grant2", 64'(got[2]), 64'(1));
        check("rr_grant3", 64'(got[3]), 64'(2));

        // long hold by master 1
        do_reset();
        req = 2'b01;
        cnt = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            ack[0] = cpr[0];
            ack[1] = cpr[1];
            if (gnt[0] != 0) cnt++;
            else if (cnt > 0) break;
            tick();
        end
`ifdef MINX_ARB_HOLD_TIMEOUT_EN
        check("timeout_len", 64'(cnt), 64'(MAXH));
        check("timeout_herr", 64'(herr[0]), 64'(1));
        req = '0;
        for (int i = 0; i < 5; i++) begin
            ack[0] = cpr[0];
            ack[1] = cpr[1];
            tick();
        end
        check("timeout_herr_sticky", 64'(herr[0]), 64'(1));
`else
        check("hold_unlimited_gnt", 64'(gnt[0]), 64'(2'b01));
        check("hold_unlimited_herr", 64'(herr[0]), 64'(0));
`endif

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("rand%0d_m%0d", i, d), act_obs(d), exp_obs(d));
            for (int b = 0; b < NR; b++)
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            for (int d = 0; d < 2; d++)
                ack[d] = ($urandom_range(3) != 0) ? cpr[d] : 1'($urandom_range(1));
            m_read       = NM'($urandom);
            m_write      = NM'($urandom);
            m_bus_status = (NM*2)'($urandom);
            m_data       = (NM*DW)'($urandom);
            if ($urandom_range(7) == 0) m_address = {24'($urandom), 24'($urandom), 24'($urandom)};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
